rgu_seq: RTL and testbench
==========================

RGU_SEQ -- requirements
Module: rgu_seq

Interface
REQ-001 Parameter NUM_RST, default 16, number of reset output channels (1..64).
REQ-002 Parameter NUM_STAGE, default 4, number of release stages (2..16); STG_W = $clog2(NUM_STAGE).
REQ-003 Parameter STAGE_MAP, default all zero, NUM_RST*STG_W bits; field i is the release stage of channel i.
REQ-004 Parameter RST_POL, default all zero, NUM_RST bits; bit i=0 means output i is active-low, bit i=1 means active-high.
REQ-005 Parameter STAGE_DLY, default 8, cycles between stage releases (1..255).
REQ-006 Parameter HOLD_CNT, default 16, global-reset assertion length in cycles (1..255).
REQ-007 Parameter MOD_HOLD, default 4, module-reset assertion length in cycles (1..15).
REQ-008 sys_clk_i  in  1  single clock; all logic in this domain.
REQ-009 por_rstn_i  in  1  reset, asynchronous assert, active-low; synchronised externally.
REQ-010 locked_i  in  1  PLL lock, level.
REQ-011 wdt_rst_req_i  in  1  watchdog global reset request, one-cycle pulse.
REQ-012 sw_rst_req_i  in  1  software global reset request, one-cycle pulse.
REQ-013 wdt_rst_en_i  in  NUM_RST  per-channel enable for watchdog reset, quasi-static.
REQ-014 sw_rst_en_i  in  NUM_RST  per-channel enable for software reset, quasi-static.
REQ-015 mod_rst_req_i  in  NUM_RST  per-channel module reset request, one-cycle pulse.
REQ-016 mod_rst_mask_i  in  NUM_RST  1 = ignore mod_rst_req_i for that channel.
REQ-017 rst_o  out  NUM_RST  registered reset outputs, polarity per RST_POL.
REQ-018 all_rel_o  out  1  high only in state RUN.
REQ-019 rst_cause_o  out  2  sticky cause: bit0 watchdog, bit1 software.

Function
REQ-020 Each channel SHALL hold an internal flag act[i] (1 = in reset); rst_o[i] = RST_POL[i] ? act[i] : ~act[i], driven straight from a flop.
REQ-021 The FSM SHALL have states IDLE, REL, RUN, HOLD.
REQ-022 IDLE: all act=1; locked_i=1 sampled -> REL, stage=0, cnt=0.
REQ-023 REL: cnt increments each cycle; at cnt==STAGE_DLY-1, act is cleared for all channels whose STAGE_MAP field equals stage, cnt is cleared and stage increments, all on the same edge.
REQ-024 REL: after stage NUM_STAGE-1 is released -> RUN on the same edge; a channel mapped to a stage >= NUM_STAGE SHALL be released with the last stage.
REQ-025 Channel i release edge = locked edge + STAGE_DLY*(STAGE_MAP[i]+1); all_rel_o rises on edge + STAGE_DLY*NUM_STAGE.
REQ-026 RUN: sw_rst_req_i or wdt_rst_req_i -> HOLD next edge; on that edge act[i] is set where (sw_req & sw_rst_en_i[i]) | (wdt_req & wdt_rst_en_i[i]); hold counter is cleared.
REQ-027 HOLD: after HOLD_CNT cycles -> REL with stage=0; REL only clears flags, so non-enabled channels stay released throughout.
REQ-028 A global request in REL or HOLD SHALL set the enabled flags, enter HOLD and restart the hold counter.
REQ-029 Global requests in IDLE SHALL be ignored, including for rst_cause_o.
REQ-030 rst_cause_o bits SHALL be set on any accepted request and cleared only by por_rstn_i; simultaneous sw and wdt requests set both bits and use the OR of the enables.
REQ-031 In RUN only, mod_rst_req_i[i] & ~mod_rst_mask_i[i] SHALL set act[i] next edge and load a per-channel counter; act[i] clears after MOD_HOLD cycles; a new pulse restarts the count.
REQ-032 Module requests SHALL be ignored outside RUN; entering HOLD SHALL cancel all module counters.
REQ-033 locked_i=0 in any state other than IDLE SHALL set all act=1, clear counters and enter IDLE next edge.

Reset
REQ-034 por_rstn_i=0 SHALL asynchronously force: state IDLE, all act=1 (rst_o=RST_POL), all_rel_o=0, rst_cause_o=0, all counters 0.

Verification
REQ-035 NUM_RST=4, STAGE_MAP={3,2,1,0}, STAGE_DLY=8: locked at edge T -> ch0..ch3 deassert at T+8/16/24/32; all_rel_o=1 at T+32.
REQ-036 RUN, sw pulse with sw_rst_en_i=4'b0101 -> ch0 and ch2 asserted for 16 cycles, then re-sequenced; ch1 and ch3 never toggle; rst_cause_o=2'b10.
REQ-037 Same-cycle sw+wdt pulses -> rst_cause_o=2'b11; asserted channels = OR of both enables.
REQ-038 Module pulse ch1 unmasked, repeated 2 cycles later -> ch1 asserted 6 cycles total; a masked pulse -> no change.
REQ-039 locked_i drop during REL stage 2 -> all outputs asserted next edge; FSM in IDLE; relock restarts from stage 0.
REQ-040 RST_POL=4'b1000: ch3 reads 1 during reset and 0 after release; por_rstn_i asserted mid-HOLD -> immediate full reset, cause cleared.

Source files
------------

// File: rtl/rgu_seq.sv
// Staged reset sequencer: releases reset channels stage by stage after PLL lock; adds sw/wdt global and per-channel module resets.
// Outputs are registered and update one edge after a request is sampled; there is no backpressure, and request pulses are never stalled.
module rgu_seq #(
  parameter int unsigned                          NUM_RST   = 16,
  parameter int unsigned                          NUM_STAGE = 4,
  parameter logic [NUM_RST*$clog2(NUM_STAGE)-1:0] STAGE_MAP = '0,
  parameter logic [NUM_RST-1:0]                   RST_POL   = '0,
  parameter int unsigned                          STAGE_DLY = 8,
  parameter int unsigned                          HOLD_CNT  = 16,
  parameter int unsigned                          MOD_HOLD  = 4
) (
  input  logic               sys_clk_i,
  input  logic               por_rstn_i,
  input  logic               locked_i,
  input  logic               wdt_rst_req_i,
  input  logic               sw_rst_req_i,
  input  logic [NUM_RST-1:0] wdt_rst_en_i,
  input  logic [NUM_RST-1:0] sw_rst_en_i,
  input  logic [NUM_RST-1:0] mod_rst_req_i,
  input  logic [NUM_RST-1:0] mod_rst_mask_i,
  output logic [NUM_RST-1:0] rst_o,
  output logic               all_rel_o,
  output logic [1:0]         rst_cause_o
);

  localparam int unsigned      STG_W    = $clog2(NUM_STAGE);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGE - 1);
  localparam logic [7:0]       DLY_END  = 8'(STAGE_DLY - 1);
  localparam logic [7:0]       HOLD_END = 8'(HOLD_CNT - 1);
  localparam logic [3:0]       MOD_LOAD = 4'(MOD_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [STG_W-1:0]             stage_q, stage_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic [7:0]                   hcnt_q, hcnt_d;
  logic [NUM_RST-1:0][3:0]      mcnt_q, mcnt_d;
  logic [1:0]                   cause_q, cause_d;
  logic [NUM_RST-1:0]           rst_q, rst_d;
  logic                         all_rel_q, all_rel_d;

  logic [NUM_RST-1:0]           act;
  logic [NUM_RST-1:0]           act_d;
  logic [NUM_RST-1:0]           en_mask;
  logic [NUM_RST-1:0]           rel_hit;
  logic [NUM_RST-1:0][STG_W-1:0] eff_stg;
  logic                         glb_req;
  logic                         stage_done;
  logic                         last_stage;
  logic                         hold_done;

  // Channels mapped beyond the last stage are folded onto it at elaboration.
  for (genvar g = 0; g < NUM_RST; g++) begin : g_map
    localparam logic [STG_W-1:0] FLD = STAGE_MAP[g*STG_W +: STG_W];
    localparam logic [STG_W-1:0] EFF = (32'(FLD) >= NUM_STAGE - 1) ? LAST_STG : FLD;
    assign eff_stg[g] = EFF;
    assign rel_hit[g] = (eff_stg[g] == stage_q);
  end

  // The output flops hold the polarity-encoded value; act is recovered by XOR.
  assign act        = rst_q ^ ~RST_POL;
  assign glb_req    = sw_rst_req_i | wdt_rst_req_i;
  assign en_mask    = ({NUM_RST{sw_rst_req_i}} & sw_rst_en_i) |
                      ({NUM_RST{wdt_rst_req_i}} & wdt_rst_en_i);
  assign stage_done = (cnt_q == DLY_END);
  assign last_stage = (stage_q == LAST_STG);
  assign hold_done  = (hcnt_q == HOLD_END);

  always_ff @(posedge sys_clk_i or negedge por_rstn_i) begin
    if (!por_rstn_i) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      mcnt_q    <= '0;
      cause_q   <= '0;
      rst_q     <= RST_POL;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      mcnt_q    <= mcnt_d;
      cause_q   <= cause_d;
      rst_q     <= rst_d;
      all_rel_q <= all_rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (locked_i) state_d = S_REL;
      end
      S_REL: begin
        if (!locked_i)                     state_d = S_IDLE;
        else if (glb_req)                  state_d = S_HOLD;
        else if (stage_done && last_stage) state_d = S_RUN;
      end
      S_RUN: begin
        if (!locked_i)    state_d = S_IDLE;
        else if (glb_req) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!locked_i)      state_d = S_IDLE;
        else if (glb_req)   state_d = S_HOLD;
        else if (hold_done) state_d = S_REL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    act_d   = act;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    mcnt_d  = mcnt_q;
    cause_d = cause_q;

    if (state_q == S_IDLE || !locked_i) begin
      act_d   = '1;
      stage_d = '0;
      cnt_d   = '0;
      hcnt_d  = '0;
      mcnt_d  = '0;
    end else if (glb_req) begin
      // A global request outranks any stage release or module timer on the same edge.
      act_d   = act | en_mask;
      stage_d = '0;
      cnt_d   = '0;
      hcnt_d  = '0;
      mcnt_d  = '0;
      cause_d = cause_q | {sw_rst_req_i, wdt_rst_req_i};
    end else begin
      unique case (state_q)
        S_REL: begin
          if (stage_done) begin
            act_d   = act & ~rel_hit;
            cnt_d   = '0;
            stage_d = last_stage ? '0 : stage_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NUM_RST; i++) begin
            if (mod_rst_req_i[i] && !mod_rst_mask_i[i]) begin
              act_d[i]  = 1'b1;
              mcnt_d[i] = MOD_LOAD;
            end else if (mcnt_q[i] != 4'd0) begin
              mcnt_d[i] = mcnt_q[i] - 4'd1;
              if (mcnt_q[i] == 4'd1) act_d[i] = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (hold_done) begin
            hcnt_d  = '0;
            stage_d = '0;
            cnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + 8'd1;
          end
        end
        default: begin
          act_d = '1;
        end
      endcase
    end

    rst_d     = act_d ^ ~RST_POL;
    all_rel_d = (state_d == S_RUN);
  end

  assign rst_o       = rst_q;
  assign all_rel_o   = all_rel_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rgu_seq.sv
// Bench for rgu_seq: timeline-based reference model checked every cycle, plus literal checks of the key sequences.
module tb_rgu_seq;
  localparam int         NR  = 4;
  localparam int         NS  = 4;
  localparam int         DLY = 8;
  localparam int         HC  = 16;
  localparam int         MH  = 4;
  localparam logic [7:0] MAP = {2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [3:0] POL = 4'b1000;

  logic          clk = 1'b0;
  logic          por_rstn = 1'b0;
  logic          locked = 1'b0;
  logic          wdt = 1'b0;
  logic          sw = 1'b0;
  logic [NR-1:0] wdt_en = '0;
  logic [NR-1:0] sw_en = '0;
  logic [NR-1:0] mreq = '0;
  logic [NR-1:0] mmask = '0;
  logic [NR-1:0] rst_o;
  logic          all_rel;
  logic [1:0]    cause;

  int total = 0;
  int bad = 0;

  rgu_seq #(
    .NUM_RST(NR), .NUM_STAGE(NS), .STAGE_MAP(MAP), .RST_POL(POL),
    .STAGE_DLY(DLY), .HOLD_CNT(HC), .MOD_HOLD(MH)
  ) dut (
    .sys_clk_i(clk), .por_rstn_i(por_rstn), .locked_i(locked),
    .wdt_rst_req_i(wdt), .sw_rst_req_i(sw),
    .wdt_rst_en_i(wdt_en), .sw_rst_en_i(sw_en),
    .mod_rst_req_i(mreq), .mod_rst_mask_i(mmask),
    .rst_o(rst_o), .all_rel_o(all_rel), .rst_cause_o(cause)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reference model: phases with start times; releases are computed from elapsed
  // time since the sequence began, module resets from absolute end times.
  typedef enum int {P_IDLE, P_SEQ, P_RUN, P_HOLD} ph_t;
  ph_t        ph = P_IDLE;
  int         n = 0;
  int         t0 = 0;
  logic [3:0] held = 4'hF;
  int         mod_end [NR] = '{0, 0, 0, 0};
  int         stg_of [NR] = '{0, 1, 2, 3};
  logic [1:0] m_cause = 2'b00;
  logic [3:0] exp_rst = POL;
  logic       exp_rel = 1'b0;
  logic [3:0] m_mact;
  logic [3:0] m_act;
  logic [3:0] m_en;

  function automatic int eff_stage(input int s);
    return (s > NS - 1) ? NS - 1 : s;
  endfunction

  initial forever begin
    @(posedge clk or negedge por_rstn);
    if (!por_rstn) begin
      ph = P_IDLE; n = 0; t0 = 0; held = 4'hF; m_cause = 2'b00;
      for (int i = 0; i < NR; i++) mod_end[i] = 0;
    end else begin
      for (int i = 0; i < NR; i++) m_mact[i] = (ph == P_RUN) && (n < mod_end[i]);
      m_act = held | m_mact;
      n++;
      m_en = (sw ? sw_en : 4'h0) | (wdt ? wdt_en : 4'h0);
      if (ph != P_IDLE && !locked) begin
        ph = P_IDLE; held = 4'hF;
        for (int i = 0; i < NR; i++) mod_end[i] = 0;
      end else if (ph == P_IDLE) begin
        if (locked) begin ph = P_SEQ; t0 = n; end
      end else if (sw || wdt) begin
        held = m_act | m_en; ph = P_HOLD; t0 = n;
        m_cause = m_cause | {sw, wdt};
        for (int i = 0; i < NR; i++) mod_end[i] = 0;
      end else if (ph == P_SEQ) begin
        for (int i = 0; i < NR; i++)
          if (n - t0 >= DLY * (eff_stage(stg_of[i]) + 1)) held[i] = 1'b0;
        if (n - t0 >= DLY * NS) ph = P_RUN;
      end else if (ph == P_RUN) begin
        for (int i = 0; i < NR; i++)
          if (mreq[i] && !mmask[i]) mod_end[i] = n + MH;
      end else begin
        if (n - t0 >= HC) begin ph = P_SEQ; t0 = n; end
      end
    end
    for (int i = 0; i < NR; i++) m_mact[i] = (ph == P_RUN) && (n < mod_end[i]);
    exp_rst = (held | m_mact) ^ ~POL;
    exp_rel = (ph == P_RUN);
  end

  initial forever begin
    @(negedge clk);
    chk("model_rst_o", rst_o, exp_rst);
    chk("model_all_rel", all_rel, exp_rel);
    chk("model_cause", cause, m_cause);
  end

  task automatic wait_run(input int lim);
    for (int k = 0; k < lim && !all_rel; k++) cyc(1);
    chk("run_reached", all_rel, 1'b1);
  endtask

  initial begin
    cyc(2);
    chk("por_rst_o", rst_o, 4'b1000);
    chk("por_all_rel", all_rel, 1'b0);
    chk("por_cause", cause, 2'b00);
    por_rstn = 1'b1;
    cyc(2);
    chk("idle_rst_o", rst_o, 4'b1000);
    // Requests while idle are ignored, cause included.
    sw = 1; wdt = 1; sw_en = '1; wdt_en = '1;
    cyc(1); sw = 0; wdt = 0; cyc(1);
    chk("idle_req_cause", cause, 2'b00);

    locked = 1'b1; cyc(1);
    cyc(7); chk("seq_t7", rst_o, 4'b1000);
    cyc(1); chk("seq_t8", rst_o, 4'b1001);
    cyc(8); chk("seq_t16", rst_o, 4'b1011);
    cyc(8); chk("seq_t24", rst_o, 4'b1111);
    cyc(7); chk("seq_t31_rel", all_rel, 1'b0);
    cyc(1); chk("seq_t32", rst_o, 4'b0111);
    chk("seq_t32_rel", all_rel, 1'b1);

    sw_en = 4'b0101; wdt_en = 4'b0000; sw = 1; cyc(1); sw = 0;
    chk("sw_assert", rst_o, 4'b0010);
    chk("sw_cause", cause, 2'b10);
    cyc(15); chk("sw_hold15", rst_o, 4'b0010);
    cyc(9);  chk("sw_ch0_rel", rst_o, 4'b0011);
    cyc(16); chk("sw_ch2_rel", rst_o, 4'b0111);
    cyc(8);  chk("sw_run", all_rel, 1'b1);

    sw_en = 4'b0001; wdt_en = 4'b1000; sw = 1; wdt = 1; cyc(1); sw = 0; wdt = 0;
    chk("both_assert", rst_o, 4'b1110);
    chk("both_cause", cause, 2'b11);
    wait_run(100);

    mreq = 4'b0010; cyc(1); mreq = 0;
    chk("mod_e0", rst_o, 4'b0101);
    cyc(1); mreq = 4'b0010; cyc(1); mreq = 0;
    cyc(3); chk("mod_e5", rst_o, 4'b0101);
    cyc(1); chk("mod_e6", rst_o, 4'b0111);
    mmask = 4'b0100; mreq = 4'b0100; cyc(1); mreq = 0;
    chk("mod_masked", rst_o, 4'b0111);
    mmask = 0;

    locked = 0; cyc(1);
    chk("unlock_run", rst_o, 4'b1000);
    locked = 1; cyc(1); cyc(19);
    chk("rel_stage2", rst_o, 4'b1011);
    locked = 0; cyc(1);
    chk("unlock_rel", rst_o, 4'b1000);
    chk("unlock_rel_all", all_rel, 1'b0);
    locked = 1; cyc(1);
    cyc(7); chk("relock_t7", rst_o, 4'b1000);
    cyc(1); chk("relock_t8", rst_o, 4'b1001);
    wait_run(100);

    sw_en = 4'b1111; sw = 1; cyc(1); sw = 0;
    cyc(5); #2 por_rstn = 0; #1;
    chk("por_mid_hold_rst", rst_o, 4'b1000);
    chk("por_mid_hold_cause", cause, 2'b00);
    chk("por_mid_hold_rel", all_rel, 1'b0);
    cyc(1); por_rstn = 1;
    wait_run(100);

    for (int c = 0; c < 3000; c++) begin
      if (locked && $urandom_range(299) == 0) locked = 0;
      else if (!locked && $urandom_range(7) == 0) locked = 1;
      sw  = ($urandom_range(69) == 0);
      wdt = ($urandom_range(89) == 0);
      if ($urandom_range(49) == 0) sw_en = 4'($urandom);
      if ($urandom_range(49) == 0) wdt_en = 4'($urandom);
      if ($urandom_range(99) == 0) mmask = 4'($urandom);
      for (int i = 0; i < NR; i++) mreq[i] = ($urandom_range(11) == 0);
      cyc(1);
    end
    sw = 0; wdt = 0; mreq = 0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
